// File: rtl/commit_trace_unit.sv
// commit_trace_unit: in-order retire log of WB register writes and MEM stores with flush/drain/done sequencing.
// Define COMMIT_TRACE_STAMP_EN to store a per-entry cycle stamp; otherwise trace_stamp is tied to 0.
module commit_trace_unit #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 16,
    parameter int FLUSH_CYCLES = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_write,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic            end_program,
    output logic            trace_valid,
    input  logic            trace_ready,
    output logic            trace_kind,
    output logic [XLEN-1:0] trace_tag,
    output logic [XLEN-1:0] trace_data,
    output logic [31:0]     trace_stamp,
    output logic [31:0]     cycle_count,
    output logic [31:0]     commit_count,
    output logic            overflow,
    output logic            done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;
    state_t          r_state;
    logic [31:0]     r_flush, r_cycle, r_commit;
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_count;
    logic            r_overflow, r_done;
    logic            r_kind [DEPTH];
    logic [XLEN-1:0] r_tag  [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic            w_cap, w_reg_ev, w_st_ev, w_pop, w_push_reg, w_push_st, w_drop, w_empty;
    logic [CW-1:0]   w_space;
    logic [AW-1:0]   w_st_idx;
    assign w_empty    = r_count == CW'(0);
    assign w_cap      = r_state == S_RUN || r_state == S_FLUSH;
    assign w_reg_ev   = w_cap && wb_reg_write && wb_rd != 5'd0;
    assign w_st_ev    = w_cap && mem_write;
    assign w_pop      = !w_empty && trace_ready;
    assign w_space    = CW'(DEPTH) - r_count + CW'(w_pop);
    // The WB write is older than the MEM store, so it claims free space first.
    assign w_push_reg = w_reg_ev && w_space != CW'(0);
    assign w_push_st  = w_st_ev && w_space > CW'(w_push_reg);
    assign w_drop     = (w_reg_ev && !w_push_reg) || (w_st_ev && !w_push_st);
    assign w_st_idx   = r_wr + AW'(w_push_reg);
    assign trace_valid  = !w_empty;
    assign trace_kind   = !w_empty && r_kind[r_rd];
    assign trace_tag    = w_empty ? '0 : r_tag[r_rd];
    assign trace_data   = w_empty ? '0 : r_data[r_rd];
    assign cycle_count  = r_cycle;
    assign commit_count = r_commit;
    assign overflow     = r_overflow;
    assign done         = r_done;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_flush    <= '0;
            r_cycle    <= '0;
            r_commit   <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr     <= r_wr + AW'(w_push_reg) + AW'(w_push_st);
            r_rd     <= r_rd + AW'(w_pop);
            r_count  <= r_count + CW'(w_push_reg) + CW'(w_push_st) - CW'(w_pop);
            r_commit <= r_commit + 32'(w_push_reg) + 32'(w_push_st);
            if (w_cap) r_cycle <= r_cycle + 32'd1;
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                S_RUN: if (end_program) begin
                    r_state <= FLUSH_CYCLES == 0 ? S_DRAIN : S_FLUSH;
                    r_flush <= 32'(FLUSH_CYCLES);
                end
                S_FLUSH: begin
                    r_flush <= r_flush - 32'd1;
                    if (r_flush == 32'd1) r_state <= S_DRAIN;
                end
                S_DRAIN: if (w_empty) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`ifdef COMMIT_TRACE_STAMP_EN
    logic [31:0] r_stamp [DEPTH];
    assign trace_stamp = w_empty ? '0 : r_stamp[r_rd];
    always_ff @(posedge clk) begin
        if (w_push_reg) r_stamp[r_wr] <= r_cycle;
        if (w_push_st) r_stamp[w_st_idx] <= r_cycle;
    end
`else
    assign trace_stamp = '0;
`endif
    // Storage needs no reset: outputs are masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_reg) begin
            r_kind[r_wr] <= 1'b0;
            r_tag[r_wr]  <= XLEN'(wb_rd);
            r_data[r_wr] <= wb_data;
        end
        if (w_push_st) begin
            r_kind[w_st_idx] <= 1'b1;
            r_tag[w_st_idx]  <= mem_addr;
            r_data[w_st_idx] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: directed checks of capture, ordering, overflow, flush/drain/done and reset.
module tb_commit_trace_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_reg_write = 1'b0, mem_write = 1'b0, end_program = 1'b0, trace_ready = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0, mem_addr = '0, mem_wdata = '0;
    logic        trace_valid, trace_kind, overflow, done;
    logic [63:0] trace_tag, trace_data;
    logic [31:0] trace_stamp, cycle_count, commit_count;
    int          n_chk = 0;
    int          n_err = 0;
    always #5 clk = ~clk;
    commit_trace_unit #(.XLEN(64), .DEPTH(16), .FLUSH_CYCLES(5)) dut (
        .clk(clk), .reset(reset),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .end_program(end_program),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_kind(trace_kind), .trace_tag(trace_tag), .trace_data(trace_data),
        .trace_stamp(trace_stamp), .cycle_count(cycle_count), .commit_count(commit_count),
        .overflow(overflow), .done(done)
    );
    function automatic logic [31:0] st(input logic [31:0] v);
`ifdef COMMIT_TRACE_STAMP_EN
        return v;
`else
        return v & 32'd0;
`endif
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic ev(input logic rw, input logic [4:0] rd, input logic [63:0] d,
                      input logic mw, input logic [63:0] a, input logic [63:0] wd);
        wb_reg_write = rw; wb_rd = rd; wb_data = d;
        mem_write = mw; mem_addr = a; mem_wdata = wd;
    endtask
    task automatic idle;
        ev(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0);
    endtask
    task automatic head(input string tag, input logic k, input logic [63:0] t, input logic [63:0] d);
        chk({tag, "_valid"}, 64'(trace_valid), 64'd1);
        chk({tag, "_kind"}, 64'(trace_kind), 64'(k));
        chk({tag, "_tag"}, trace_tag, t);
        chk({tag, "_data"}, trace_data, d);
    endtask
    task automatic reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(trace_valid), 64'd0);
        chk({tag, "_kind"}, 64'(trace_kind), 64'd0);
        chk({tag, "_tag"}, trace_tag, 64'd0);
        chk({tag, "_data"}, trace_data, 64'd0);
        chk({tag, "_stamp"}, 64'(trace_stamp), 64'd0);
        chk({tag, "_cyc"}, 64'(cycle_count), 64'd0);
        chk({tag, "_commit"}, 64'(commit_count), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask
    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask
    task automatic wait_cycle(input string tag, input logic [31:0] c);
        for (int k = 0; k < 200 && cycle_count != c; k++) tick;
        chk(tag, 64'(cycle_count), 64'(c));
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end
    initial begin
        tick;
        reset_vals("rst");
        reset = 1'b0;
        trace_ready = 1'b1;
        tick;
        chk("first_cyc", 64'(cycle_count), 64'd1);
        ev(1'b1, 5'd2, 64'd7, 1'b0, 64'd0, 64'd0);
        tick;
        idle;
        head("t1", 1'b0, 64'd2, 64'd7);
        chk("t1_stamp", 64'(trace_stamp), 64'(st(32'd1)));
        chk("t1_commit", 64'(commit_count), 64'd1);
        ev(1'b1, 5'd0, 64'd99, 1'b1, 64'd8, 64'h55);
        tick;
        idle;
        head("t2", 1'b1, 64'd8, 64'h55);
        chk("t2_commit", 64'(commit_count), 64'd2);
        tick;
        reset_vals_empty: begin
            chk("t2_empty_valid", 64'(trace_valid), 64'd0);
            chk("t2_empty_data", trace_data, 64'd0);
        end
        trace_ready = 1'b0;
        ev(1'b1, 5'd3, 64'd9, 1'b1, 64'd16, 64'd4);
        tick;
        idle;
        head("t3a", 1'b0, 64'd3, 64'd9);
        chk("t3_commit", 64'(commit_count), 64'd4);
        trace_ready = 1'b1;
        tick;
        head("t3b", 1'b1, 64'd16, 64'd4);
        tick;
        chk("t3_empty", 64'(trace_valid), 64'd0);
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ev(1'b0, 5'd0, 64'd0, 1'b1, 64'(i), 64'(i * 3 + 100));
            tick;
        end
        idle;
        chk("t4_full_commit", 64'(commit_count), 64'd20);
        chk("t4_full_ovf", 64'(overflow), 64'd0);
        head("t4_head0", 1'b1, 64'd0, 64'd100);
        trace_ready = 1'b1;
        ev(1'b0, 5'd0, 64'd0, 1'b1, 64'd16, 64'd148);
        tick;
        idle;
        chk("t4_pushpop_commit", 64'(commit_count), 64'd21);
        chk("t4_pushpop_ovf", 64'(overflow), 64'd0);
        trace_ready = 1'b0;
        ev(1'b0, 5'd0, 64'd0, 1'b1, 64'd17, 64'd151);
        tick;
        idle;
        chk("t4_drop_commit", 64'(commit_count), 64'd21);
        chk("t4_drop_ovf", 64'(overflow), 64'd1);
        trace_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            head("t4_drain", 1'b1, 64'(i), 64'(i * 3 + 100));
            tick;
        end
        chk("t4_empty", 64'(trace_valid), 64'd0);
        do_reset;
        trace_ready = 1'b0;
        wait_cycle("t5_reach", 32'd19);
        end_program = 1'b1;
        ev(1'b1, 5'd5, 64'haa, 1'b1, 64'h40, 64'hbb);
        tick;
        idle;
        chk("t5_commit_a", 64'(commit_count), 64'd2);
        head("t5_first", 1'b0, 64'd5, 64'haa);
        chk("t5_stamp", 64'(trace_stamp), 64'(st(32'd19)));
        repeat (4) tick;
        ev(1'b1, 5'd6, 64'hcc, 1'b0, 64'd0, 64'd0);
        tick;
        ev(1'b1, 5'd7, 64'hdd, 1'b1, 64'h80, 64'hee);
        chk("t5_freeze", 64'(cycle_count), 64'd25);
        chk("t5_commit_b", 64'(commit_count), 64'd3);
        tick;
        idle;
        chk("t5_drain_nocap", 64'(commit_count), 64'd3);
        chk("t5_drain_cyc", 64'(cycle_count), 64'd25);
        trace_ready = 1'b1;
        head("t5_pop0", 1'b0, 64'd5, 64'haa);
        tick;
        head("t5_pop1", 1'b1, 64'h40, 64'hbb);
        tick;
        head("t5_pop2", 1'b0, 64'd6, 64'hcc);
        tick;
        chk("t5_done_early", 64'(done), 64'd0);
        chk("t5_empty", 64'(trace_valid), 64'd0);
        tick;
        chk("t5_done", 64'(done), 64'd1);
        repeat (3) tick;
        chk("t5_done_hold", 64'(done), 64'd1);
        chk("t5_cyc_hold", 64'(cycle_count), 64'd25);
        do_reset;
        trace_ready = 1'b0;
        tick;
        end_program = 1'b1;
        ev(1'b1, 5'd1, 64'd1, 1'b1, 64'h100, 64'd2);
        tick;
        ev(1'b1, 5'd2, 64'd3, 1'b0, 64'd0, 64'd0);
        tick;
        idle;
        chk("t6_commit", 64'(commit_count), 64'd3);
        chk("t6_valid", 64'(trace_valid), 64'd1);
        reset = 1'b1;
        tick;
        reset_vals("t6_rst");
        reset = 1'b0;
        end_program = 1'b0;
        tick;
        chk("t6_cyc1", 64'(cycle_count), 64'd1);
        chk("t6_valid_after", 64'(trace_valid), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
